// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr
//  Captures request pulses into a sticky pending vector and hands out one
//  encoded index per accepted valid/ready transfer. Highest index wins by
//  default; defining PE_ROUND_ROBIN_EN replaces that with a descending
//  round-robin search that starts just below the last accepted index.
//  Reset is synchronous and active-low.
module priority_encoder_rr #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 y_ready,
    output logic [$clog2(N)-1:0] y,
    output logic [N-1:0]         y_onehot,
    output logic                 y_valid,
    output logic [N-1:0]         pending
);

    localparam int W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_r;
    logic [W-1:0]   y_r;
    logic [N-1:0]   y_onehot_r;
    logic           y_valid_r;
    logic [N-1:0]   pending_r;

    logic           accept_s;
    logic [N-1:0]   clr_s;
    logic [N-1:0]   cand_s;
    logic           cand_any_s;
    logic [W-1:0]   sel_s;
    logic [N-1:0]   sel_onehot_s;

`ifdef PE_ROUND_ROBIN_EN
    logic [W-1:0]   rr_ptr_r;
    logic [W-1:0]   rr_ptr_next_s;

    // Descending search from start with wrap-around; first hit wins.
    function automatic logic [W-1:0] pick_rr(input logic [N-1:0] c, input logic [W-1:0] start);
        logic [W-1:0] r;
        logic         found;
        int           t;
        r     = {W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            t = int'(start) - i;
            if (t < 0) begin
                t = t + N;
            end else begin
                t = t;
            end
            if (!found && c[W'(t)]) begin
                r     = W'(t);
                found = 1'b1;
            end else begin
                r     = r;
            end
        end
        return r;
    endfunction
`else
    // Highest set index wins; later (higher) hits overwrite earlier ones.
    function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] c);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (c[W'(i)]) begin
                r = W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction
`endif

    // Next pending vector, candidate set and the winning index for this edge.
    always_comb begin
        accept_s = y_valid_r & y_ready;
        if (accept_s) begin
            clr_s = y_onehot_r;
        end else begin
            clr_s = {N{1'b0}};
        end
        if (en) begin
            cand_s = (pending_r & ~clr_s) | req;
        end else begin
            cand_s = pending_r & ~clr_s;
        end
        cand_any_s = |cand_s;
`ifdef PE_ROUND_ROBIN_EN
        // The grant loaded on an accepting edge must already see the advanced pointer.
        if (accept_s) begin
            if (y_r == {W{1'b0}}) begin
                rr_ptr_next_s = W'(N - 1);
            end else begin
                rr_ptr_next_s = y_r - W'(1);
            end
        end else begin
            rr_ptr_next_s = rr_ptr_r;
        end
        sel_s = pick_rr(cand_s, rr_ptr_next_s);
`else
        sel_s = pick_fixed(cand_s);
`endif
        sel_onehot_s = {{(N-1){1'b0}}, 1'b1} << sel_s;
    end

`ifdef PE_ROUND_ROBIN_EN
    // Round-robin pointer: restarts at the top index after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= W'(N - 1);
        end else begin
            rr_ptr_r <= rr_ptr_next_s;
        end
    end
`endif

    // Grant FSM: IDLE waits for a candidate, HOLD keeps the grant until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            y_r        <= {W{1'b0}};
            y_onehot_r <= {N{1'b0}};
            y_valid_r  <= 1'b0;
            pending_r  <= {N{1'b0}};
        end else begin
            pending_r <= cand_s;
            case (state_r)
                IDLE: begin
                    if (en && cand_any_s) begin
                        y_r        <= sel_s;
                        y_onehot_r <= sel_onehot_s;
                        y_valid_r  <= 1'b1;
                        state_r    <= HOLD;
                    end else begin
                        y_onehot_r <= {N{1'b0}};
                        y_valid_r  <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                HOLD: begin
                    if (y_ready) begin
                        if (en && cand_any_s) begin
                            y_r        <= sel_s;
                            y_onehot_r <= sel_onehot_s;
                            y_valid_r  <= 1'b1;
                            state_r    <= HOLD;
                        end else begin
                            y_onehot_r <= {N{1'b0}};
                            y_valid_r  <= 1'b0;
                            state_r    <= IDLE;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    y_r        <= {W{1'b0}};
                    y_onehot_r <= {N{1'b0}};
                    y_valid_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign y        = y_r;
    assign y_onehot = y_onehot_r;
    assign y_valid  = y_valid_r;
    assign pending  = pending_r;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr
//  Directed sequence plus a short random phase. A behavioural model predicts
//  the outputs for every edge into a scoreboard queue; directed spot checks
//  compare key outputs against hand-derived constants.
module tb_priority_encoder_rr;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic         y_ready;
    logic [W-1:0] y;
    logic [N-1:0] y_onehot;
    logic         y_valid;
    logic [N-1:0] pending;

    always #5 clk = ~clk;

    priority_encoder_rr #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .y_ready  (y_ready),
        .y        (y),
        .y_onehot (y_onehot),
        .y_valid  (y_valid),
        .pending  (pending)
    );

    typedef struct packed {
        logic [W-1:0] y;
        logic [N-1:0] oh;
        logic         v;
        logic [N-1:0] p;
    } exp_t;

    exp_t sb_q[$];

    logic [W-1:0] m_y   = '0;
    logic [N-1:0] m_oh  = '0;
    logic         m_v   = 1'b0;
    logic [N-1:0] m_p   = '0;
    int           m_ptr = N - 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Returns the winning index of c, or -1 when c is empty.
    function automatic int pick(input logic [N-1:0] c, input int start);
        int r;
        int k;
        r = -1;
`ifdef PE_ROUND_ROBIN_EN
        for (int i = 0; i < N; i++) begin
            k = (start - i + N) % N;
            if (r < 0 && c[k]) r = k;
        end
`else
        k = start;
        for (int i = N - 1; i >= 0; i--) begin
            if (r < 0 && c[i]) r = i;
        end
`endif
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] np;
        logic         acc;
        int           k;
        exp_t         e;
        if (!rst_n) begin
            m_y = '0; m_oh = '0; m_v = 1'b0; m_p = '0; m_ptr = N - 1;
        end else begin
            acc = m_v && y_ready;
            np  = m_p;
            if (acc) begin
                np[m_y] = 1'b0;
                m_ptr = (m_y == 0) ? N - 1 : int'(m_y) - 1;
            end
            if (en) np = np | req;
            if (!m_v || acc) begin
                k = en ? pick(np, m_ptr) : -1;
                if (k >= 0) begin
                    m_v = 1'b1; m_y = W'(k); m_oh = '0; m_oh[k] = 1'b1;
                end else begin
                    m_v = 1'b0; m_oh = '0;
                end
            end
            m_p = np;
        end
        e.y = m_y; e.oh = m_oh; e.v = m_v; e.p = m_p;
        sb_q.push_back(e);
    endtask

    // Advance one clock with the currently driven inputs and check the scoreboard.
    task automatic step();
        exp_t e;
        exp_t o;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        o.y = y; o.oh = y_onehot; o.v = y_valid; o.p = pending;
        n_checks = n_checks + 1;
        assert (o === e) n_pass = n_pass + 1;
        else $error("FAIL sb t=%0t observed y=%0d oh=%h v=%b p=%h expected y=%0d oh=%h v=%b p=%h",
                    $time, o.y, o.oh, o.v, o.p, e.y, e.oh, e.v, e.p);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [W-1:0] mode_seq [9];
`ifdef PE_ROUND_ROBIN_EN
        mode_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        mode_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        rst_n = 1'b0; en = 1'b1; req = 8'hFF; y_ready = 1'b0;
        #2;

        // 1. reset with requests asserted
        step(); step();
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_valid", 32'(y_valid), 32'd0);
        chk("reset_onehot", 32'(y_onehot), 32'h00);
        chk("reset_pending", 32'(pending), 32'h00);

        // 2. drain of 8'hA4
        rst_n = 1'b1; req = 8'hA4; y_ready = 1'b1;
        step();
        chk("drain_y7", 32'(y), 32'd7);
        chk("drain_oh7", 32'(y_onehot), 32'h80);
        req = 8'h00;
        step();
        chk("drain_y5", 32'(y), 32'd5);
        step();
        chk("drain_y2", 32'(y), 32'd2);
        step();
        chk("drain_valid0", 32'(y_valid), 32'd0);
        chk("drain_pending0", 32'(pending), 32'h00);

        // 3. backpressure: low grant held while a higher request arrives
        y_ready = 1'b0; req = 8'h01;
        step();
        req = 8'h00;
        step();
        req = 8'h80;
        step();
        chk("bp_y_held", 32'(y), 32'd0);
        chk("bp_valid", 32'(y_valid), 32'd1);
        chk("bp_pending", 32'(pending), 32'h81);
        req = 8'h00; y_ready = 1'b1;
        step();
        chk("bp_y7", 32'(y), 32'd7);
        step();
        chk("bp_valid0", 32'(y_valid), 32'd0);

        // 4. disable: requests ignored; a held grant still completes
        en = 1'b0; req = 8'hFF;
        step(); step(); step();
        chk("dis_valid0", 32'(y_valid), 32'd0);
        chk("dis_pending0", 32'(pending), 32'h00);
        en = 1'b1; req = 8'h08; y_ready = 1'b0;
        step();
        chk("dis_y3", 32'(y), 32'd3);
        en = 1'b0; req = 8'h00; y_ready = 1'b1;
        step();
        chk("dis_accept_valid0", 32'(y_valid), 32'd0);
        chk("dis_accept_y_kept", 32'(y), 32'd3);

        // 5. mode sequence with all requests held
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; en = 1'b1; req = 8'hFF; y_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("mode_y%0d", i), 32'(y), 32'(mode_seq[i]));
        end

        // 6. reset while a grant is held
        rst_n = 1'b0; req = 8'h00;
        step();
        rst_n = 1'b1; req = 8'h04;
        step();
        req = 8'h00;
        step();
        y_ready = 1'b0; req = 8'h1C;
        step();
        req = 8'h00;
        step();
        chk("midrst_y4", 32'(y), 32'd4);
        chk("midrst_pending", 32'(pending), 32'h1C);
        rst_n = 1'b0;
        step();
        chk("midrst_valid0", 32'(y_valid), 32'd0);
        chk("midrst_pending0", 32'(pending), 32'h00);
        rst_n = 1'b1; req = 8'h81; y_ready = 1'b1;
        step();
        chk("midrst_first_y", 32'(y), 32'd7);

        // random phase, checked only by the scoreboard
        for (int i = 0; i < 60; i++) begin
            en      = ($urandom_range(0, 7) != 0);
            req     = N'($urandom) & N'($urandom) & N'($urandom);
            y_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
